// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register.
package usr_pkg;

  localparam int USR_MODE_W = 2;

  typedef enum logic [USR_MODE_W-1:0] {
    USR_HOLD = 2'b00,
    USR_SHR  = 2'b01,
    USR_SHL  = 2'b10,
    USR_LOAD = 2'b11
  } usr_mode_e;

endpackage

// File: rtl/usr_bit_counter.sv
// Shift counter and end-of-word pulse; a load clears the count and suppresses the pulse.
module usr_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             load,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Stage p0: count register and registered end-of-word pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (load) begin
        bit_cnt <= '0;
      end else if (shift) begin
        if (bit_cnt == LAST) begin
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load.
// Define USR_CNT_EN to build in the bit counter and word_done pulse.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [USR_MODE_W-1:0]    mode,
  input  logic                     sin_r,
  input  logic                     sin_l,
  input  logic [WIDTH-1:0]         pdata_in,
  output logic [WIDTH-1:0]         pdata_out,
  output logic                     sout_r,
  output logic                     sout_l,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     word_done
);

  logic [WIDTH-1:0] shreg_p0;

  // Stage p0: data register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_p0 <= '0;
    end else if (en) begin
      case (usr_mode_e'(mode))
        USR_SHR:  shreg_p0 <= {sin_r, shreg_p0[WIDTH-1:1]};
        USR_SHL:  shreg_p0 <= {shreg_p0[WIDTH-2:0], sin_l};
        USR_LOAD: shreg_p0 <= pdata_in;
        default:  shreg_p0 <= shreg_p0;
      endcase
    end
  end

  assign pdata_out = shreg_p0;
  assign sout_r    = shreg_p0[0];
  assign sout_l    = shreg_p0[WIDTH-1];

`ifdef USR_CNT_EN
  logic shift;
  logic load;

  always_comb begin
    shift = 1'b0;
    load  = 1'b0;
    if (en) begin
      shift = (usr_mode_e'(mode) == USR_SHR) || (usr_mode_e'(mode) == USR_SHL);
      load  = (usr_mode_e'(mode) == USR_LOAD);
    end
  end

  usr_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W ($clog2(WIDTH))
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .shift     (shift),
    .load      (load),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );
`else
  assign bit_cnt   = '0;
  assign word_done = 1'b0;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=4; counter expectations follow USR_CNT_EN.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       sin_r;
  logic       sin_l;
  logic [3:0] pdata_in;
  logic [3:0] pdata_out;
  logic       sout_r;
  logic       sout_l;
  logic [1:0] bit_cnt;
  logic       word_done;

  int nchk = 0;
  int nerr = 0;

  univ_shift_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .pdata_in  (pdata_in),
    .pdata_out (pdata_out),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int v);
`ifdef USR_CNT_EN
    return 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction

  function automatic logic [31:0] ewd(input int v);
`ifdef USR_CNT_EN
    return 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction

  // Drive one cycle's inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                      input logic [3:0] pd);
    en = e; mode = m; sin_r = sr; sin_l = sl; pdata_in = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] d, input int c, input int w);
    chk({tag, ".data"}, 32'(pdata_out), 32'(d));
    chk({tag, ".cnt"}, 32'(bit_cnt), ecnt(c));
    chk({tag, ".wd"}, 32'(word_done), ewd(w));
  endtask

  logic [3:0] sr_vec [8] = '{4'b1000, 4'b0100, 4'b1010, 4'b1101,
                             4'b1110, 4'b0111, 4'b1011, 4'b1101};
  logic       sr_in  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] sl_vec [4] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100};
  logic       sl_in  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pdata_in = 4'h0;
    #1;
    expect_state("rst_init", 4'b0000, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset between edges after a load and a shift
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b1111);
    expect_state("ld1111", 4'b1111, 0, 0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 4'b0000);
    expect_state("shr_pre_rst", 4'b0111, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    expect_state("async_rst", 4'b0000, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Shift right across a full word (first shift after reset counts as 1)
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b01, sr_in[i], 1'b0, 4'h0);
      expect_state($sformatf("shr%0d", i), sr_vec[i], (i + 1) % 4, (i == 3) ? 1 : 0);
    end
    chk("shr.sout_r", 32'(sout_r), 32'(1));
    step(1'b1, 2'b00, 1'b1, 1'b1, 4'hF);
    expect_state("hold_mode0", 4'b1101, 0, 0);

    // Shift left across a full word
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b0000);
    expect_state("ld0000", 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b10, 1'b0, sl_in[i], 4'h0);
      expect_state($sformatf("shl%0d", i), sl_vec[i], (i + 1) % 4, (i == 3) ? 1 : 0);
    end
    chk("shl.sout_l", 32'(sout_l), 32'(1));

    // Load then two right shifts
    step(1'b1, 2'b11, 1'b1, 1'b1, 4'b1010);
    expect_state("ld1010", 4'b1010, 0, 0);
    chk("ld1010.sout_r", 32'(sout_r), 32'(0));
    step(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
    expect_state("ld_shr1", 4'b0101, 1, 0);
    chk("ld_shr1.sout_r", 32'(sout_r), 32'(1));
    step(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
    expect_state("ld_shr2", 4'b0010, 2, 0);
    chk("ld_shr2.sout_r", 32'(sout_r), 32'(0));

    // Third shift, then a load at count 3 wins over the wrap
    step(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
    expect_state("ld_shr3", 4'b0001, 3, 0);
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
    expect_state("ld_prio", 4'b0110, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b01, 1'b1, 1'b1, 4'hF);
      expect_state($sformatf("en0_%0d", i), 4'b0110, 0, 0);
    end

    // Count continues across direction changes and holds while disabled
    step(1'b1, 2'b10, 1'b0, 1'b1, 4'h0);
    expect_state("mix1", 4'b1101, 1, 0);
    step(1'b0, 2'b10, 1'b0, 1'b1, 4'h0);
    expect_state("mix_hold", 4'b1101, 1, 0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
    expect_state("mix2", 4'b0110, 2, 0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 4'h0);
    expect_state("mix3", 4'b1100, 3, 0);
    step(1'b1, 2'b01, 1'b1, 1'b0, 4'h0);
    expect_state("mix4", 4'b1110, 0, 1);
    step(1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
    expect_state("mix_after", 4'b1110, 0, 0);

    // Eight right shifts: two word_done pulses when counting
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b0000);
    expect_state("ld8", 4'b0000, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b01, sr_in[i], 1'b0, 4'h0);
      expect_state($sformatf("shr8_%0d", i), sr_vec[i], (i + 1) % 4,
                   (i == 3 || i == 7) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 4, register length in bits (legal range 2..64).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port: en  input  1  clock enable; when 0, the block SHALL hold all state.
REQ-005 Port: mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 Port: sin_r  input  1  serial input entering at bit WIDTH-1 on a right shift.
REQ-007 Port: sin_l  input  1  serial input entering at bit 0 on a left shift.
REQ-008 Port: pdata_in  input  WIDTH  parallel load data.
REQ-009 Port: pdata_out  output  WIDTH  register contents.
REQ-010 Port: sout_r  output  1  equals pdata_out[0].
REQ-011 Port: sout_l  output  1  equals pdata_out[WIDTH-1].
REQ-012 Port: bit_cnt  output  $clog2(WIDTH)  number of shifts completed in the current word.
REQ-013 Port: word_done  output  1  one-cycle pulse marking completion of WIDTH shifts.

Function
REQ-014 With en=1 and mode=01, each rising edge SHALL load data <= {sin_r, data[WIDTH-1:1]}.
REQ-015 With en=1 and mode=10, each rising edge SHALL load data <= {data[WIDTH-2:0], sin_l}.
REQ-016 With en=1 and mode=11, each rising edge SHALL load data <= pdata_in and clear bit_cnt to 0.
REQ-017 With mode=00 or en=0, data and bit_cnt SHALL hold, and word_done SHALL be 0 in the following cycle.
REQ-018 Each shift (mode 01 or 10, en=1) SHALL increment bit_cnt; a shift taken at bit_cnt=WIDTH-1 SHALL wrap bit_cnt to 0.
REQ-019 The edge that performs that wrapping shift SHALL also set word_done=1 for exactly one cycle; every other edge SHALL set it to 0.
REQ-020 bit_cnt SHALL continue counting across changes of shift direction; only a load or reset clears it.
REQ-021 A load at bit_cnt=WIDTH-1 SHALL take priority: bit_cnt becomes 0 and no word_done pulse is produced.
REQ-022 All outputs SHALL be registered or direct slices of registers; there is no combinational path from inputs to outputs.
REQ-023 Latency: a shift or load is visible on pdata_out, sout_r and sout_l one edge after sampling.

Reset
REQ-024 rst=0 SHALL immediately force pdata_out=0, bit_cnt=0 and word_done=0, independent of clk.
REQ-025 Reset asserted mid-word SHALL abandon the word; the first shift after release SHALL count as shift 1.
REQ-026 The block SHALL resume normal operation on the first rising edge with rst=1.

Configuration
REQ-027 Macro USR_CNT_EN, when defined, SHALL compile in the bit counter and word_done logic per REQ-016 to REQ-021.
REQ-028 When USR_CNT_EN is undefined, bit_cnt and word_done SHALL be tied to 0, and the shift and load behaviour SHALL be unchanged.

Structure
REQ-029 Package usr_pkg SHALL hold the mode typedef (USR_HOLD, USR_SHR, USR_SHL, USR_LOAD) and the 2-bit mode width constant.
REQ-030 The counter and word_done logic SHALL reside in sub-module usr_bit_counter, instantiated only under USR_CNT_EN.

Verification (WIDTH=4, USR_CNT_EN defined unless stated)
REQ-031 Reset: load 1111, shift once, then drive rst=0 between edges -> pdata_out=0000, bit_cnt=0, word_done=0 with no clock edge.
REQ-032 Shift right: sin_r=1,0,1,1 on 4 edges -> pdata_out 1000, 0100, 1010, 1101; word_done=1 only after the 4th edge; bit_cnt back to 0.
REQ-033 Shift left: sin_l=1,1,0,0 -> pdata_out 0001, 0011, 0110, 1100; sout_l after the 4th edge = 1.
REQ-034 Load 1010, then 2 right shifts with sin_r=0 -> 0101, 0010; bit_cnt 0, 1, 2; sout_r 1, 0.
REQ-035 Three shifts, then a load of 0110 -> bit_cnt=0, no word_done pulse; then en=0 for 3 cycles -> 0110 held.
REQ-036 USR_CNT_EN undefined: 8 right shifts -> word_done and bit_cnt stay 0, and data matches REQ-032.
